alu_issue_ctrl: RTL and testbench

Per-lane occupancy controller for the `N` function-unit lanes fed by the reservation station. It produces the `alu_in_usage` busy mask the RS consults before issuing. It also counts down each lane's execution latency and sequences each result onto its CDB port under a valid/ready handshake, holding the lane until the result is accepted. It sits between RS issue and the CDB/PRF writeback path.

---
 rtl/alu_issue_ctrl_pkg.sv | 14 +
 rtl/alu_lane_fsm.sv | 88 ++++++++
 rtl/alu_issue_ctrl.sv | 54 +++++
 tb/tb_alu_issue_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared lane-controller definitions: default geometry and the per-lane state encoding.
package alu_issue_ctrl_pkg;

    localparam int N_LANES   = 2;
    localparam int LAT_W_DEF = 3;
    localparam int PRF_DEF   = 64;

    typedef enum logic [1:0] {
        LANE_IDLE = 2'd0,
        LANE_EXEC = 2'd1,
        LANE_WB   = 2'd2
    } lane_state_t;

endpackage

// File: rtl/alu_lane_fsm.sv
// One function-unit lane: latency down-counter, destination tag and CDB handshake.
module alu_lane_fsm
    import alu_issue_ctrl_pkg::*;
#(
    parameter int LAT_W = LAT_W_DEF,
    parameter int TAG_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    input  logic             issue_valid,
    input  logic [LAT_W-1:0] issue_lat,
    input  logic [TAG_W-1:0] issue_prf_idx,
    input  logic             cdb_ready,
    output logic             busy,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_prf_idx,
    output logic             issue_err
);

    lane_state_t      state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [LAT_W-1:0] eff_lat;
    logic             accept;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= LANE_IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        busy    = (state_q == LANE_EXEC) | ((state_q == LANE_WB) & ~cdb_ready);
        accept  = issue_valid & ~busy;
        eff_lat = (issue_lat == '0) ? LAT_W'(1) : issue_lat;

        if (squash) begin
            state_d = LANE_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                LANE_IDLE, LANE_WB: begin
                    // A WB slot being released this cycle can be refilled without a bubble.
                    if (state_q == LANE_IDLE || cdb_ready) begin
                        state_d = LANE_IDLE;
                        if (accept) begin
                            tag_d = issue_prf_idx;
                            if (eff_lat == LAT_W'(1)) begin
                                state_d = LANE_WB;
                                cnt_d   = '0;
                            end else begin
                                state_d = LANE_EXEC;
                                cnt_d   = eff_lat - LAT_W'(1);
                            end
                        end
                    end
                end
                LANE_EXEC: begin
                    if (cnt_q <= LAT_W'(1)) begin
                        state_d = LANE_WB;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - LAT_W'(1);
                    end
                end
                default: begin
                    state_d = LANE_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign issue_err   = issue_valid & busy;
    assign cdb_valid   = (state_q == LANE_WB);
    assign cdb_prf_idx = cdb_valid ? tag_q : '0;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Occupancy/writeback controller for the RS-fed function-unit lanes; one CDB port per lane.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int N     = N_LANES,
    parameter int LAT_W = LAT_W_DEF,
    parameter int PRF   = PRF_DEF
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               squash,
    input  logic [N-1:0]                       issue_valid,
    input  logic [N-1:0][LAT_W-1:0]            issue_lat,
    input  logic [N-1:0][$clog2(PRF)-1:0]      issue_prf_idx,
    input  logic [N-1:0]                       cdb_ready,
    output logic [N-1:0]                       alu_in_usage,
    output logic [N-1:0]                       cdb_valid,
    output logic [N-1:0][$clog2(PRF)-1:0]      cdb_prf_idx,
    output logic                               issue_err
);

    localparam int TAG_W = $clog2(PRF);

    logic [N-1:0] err_vec;

    for (genvar k = 0; k < N; k++) begin : g_lane
        alu_lane_fsm #(
            .LAT_W (LAT_W),
            .TAG_W (TAG_W)
        ) u_lane (
            .clock         (clock),
            .reset         (reset),
            .squash        (squash),
            .issue_valid   (issue_valid[k]),
            .issue_lat     (issue_lat[k]),
            .issue_prf_idx (issue_prf_idx[k]),
            .cdb_ready     (cdb_ready[k]),
            .busy          (alu_in_usage[k]),
            .cdb_valid     (cdb_valid[k]),
            .cdb_prf_idx   (cdb_prf_idx[k]),
            .issue_err     (err_vec[k])
        );
    end

    // Sticky until reset; squash deliberately leaves it alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issue_err <= 1'b0;
        end else if (|err_vec) begin
            issue_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a per-lane expected-result scoreboard.
module tb_alu_issue_ctrl;

    localparam int N     = 2;
    localparam int LAT_W = 3;
    localparam int PRF   = 64;
    localparam int TW    = $clog2(PRF);

    logic                   clock;
    logic                   reset;
    logic                   squash;
    logic [N-1:0]           issue_valid;
    logic [N-1:0][LAT_W-1:0] issue_lat;
    logic [N-1:0][TW-1:0]   issue_prf_idx;
    logic [N-1:0]           cdb_ready;
    logic [N-1:0]           alu_in_usage;
    logic [N-1:0]           cdb_valid;
    logic [N-1:0][TW-1:0]   cdb_prf_idx;
    logic                   issue_err;

    typedef struct {
        int tag;
        int cyc;
    } exp_t;

    exp_t     q0[$];
    exp_t     q1[$];
    bit [1:0] seen;
    int       cycle;
    int       nasrt;
    int       nfail;

    alu_issue_ctrl #(.N(N), .LAT_W(LAT_W), .PRF(PRF)) dut (
        .clock         (clock),
        .reset         (reset),
        .squash        (squash),
        .issue_valid   (issue_valid),
        .issue_lat     (issue_lat),
        .issue_prf_idx (issue_prf_idx),
        .cdb_ready     (cdb_ready),
        .alu_in_usage  (alu_in_usage),
        .cdb_valid     (cdb_valid),
        .cdb_prf_idx   (cdb_prf_idx),
        .issue_err     (issue_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int k, input int lat, input int tag, input bit accepted);
        exp_t e;
        issue_valid[k]   = 1'b1;
        issue_lat[k]     = LAT_W'(lat);
        issue_prf_idx[k] = TW'(tag);
        if (accepted) begin
            e.tag = tag;
            e.cyc = cycle + ((lat == 0) ? 1 : lat);
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic mon_lane(input int k);
        exp_t e;
        bit   have;
        have = 1'b0;
        e.tag = 0;
        e.cyc = 0;
        if (k == 0 && q0.size() > 0) begin e = q0[0]; have = 1'b1; end
        if (k == 1 && q1.size() > 0) begin e = q1[0]; have = 1'b1; end
        if (cdb_valid[k]) begin
            if (!have) begin
                chk($sformatf("unexpected_valid%0d", k), 32'(cdb_valid[k]), 32'd0);
            end else begin
                if (!seen[k]) begin
                    chk($sformatf("first_valid_cycle%0d", k), 32'(cycle), 32'(e.cyc));
                    seen[k] = 1'b1;
                end
                chk($sformatf("cdb_tag%0d", k), 32'(cdb_prf_idx[k]), 32'(e.tag));
                if (cdb_ready[k]) begin
                    if (k == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                    seen[k] = 1'b0;
                end
            end
        end else if (have && cycle >= e.cyc) begin
            chk($sformatf("late_result%0d", k), 32'(cdb_valid[k]), 32'd1);
        end
    endtask

    task automatic cyc();
        #1;
        mon_lane(0);
        mon_lane(1);
        @(posedge clock);
        #1;
        cycle++;
        issue_valid = '0;
    endtask

    task automatic flush();
        q0.delete();
        q1.delete();
        seen = '0;
    endtask

    initial begin
        nasrt = 0;
        nfail = 0;
        cycle = 0;
        seen  = '0;
        reset = 1'b1;
        squash = 1'b0;
        issue_valid = '0;
        issue_lat = '0;
        issue_prf_idx = '0;
        cdb_ready = 2'b11;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_usage", 32'(alu_in_usage), 32'd0);
        chk("rst_valid", 32'(cdb_valid), 32'd0);
        chk("rst_prf", 32'(cdb_prf_idx), 32'd0);
        chk("rst_err", 32'(issue_err), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        cycle = 0;

        // back-to-back L=1 on lane0, L=4 on lane1
        issue(0, 1, 5, 1'b1);
        issue(1, 4, 9, 1'b1);
        #1 chk("usage_t0", 32'(alu_in_usage), 32'd0);
        cyc();
        issue(0, 1, 6, 1'b1);
        #1 chk("usage_t1", 32'(alu_in_usage), 32'b10);
        cyc();
        #1 chk("usage_t2", 32'(alu_in_usage), 32'b10);
        cyc();
        #1 chk("usage_t3", 32'(alu_in_usage), 32'b10);
        cyc();
        #1 chk("usage_t4", 32'(alu_in_usage), 32'd0);
        chk("valid_t4", 32'(cdb_valid), 32'b10);
        cyc();

        // stalled writeback on lane0
        cdb_ready = 2'b10;
        issue(0, 2, 3, 1'b1);
        cyc();
        cyc();
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_usage", 32'(alu_in_usage[0]), 32'd1);
            chk("stall_valid", 32'(cdb_valid[0]), 32'd1);
            chk("stall_tag", 32'(cdb_prf_idx[0]), 32'd3);
            cyc();
        end
        cdb_ready = 2'b11;
        #1 chk("release_usage", 32'(alu_in_usage[0]), 32'd0);
        chk("release_valid", 32'(cdb_valid[0]), 32'd1);
        cyc();
        #1 chk("idle_after_release", 32'(cdb_valid[0]), 32'd0);

        // issue into a busy lane
        issue(1, 3, 12, 1'b1);
        #1 chk("err_before", 32'(issue_err), 32'd0);
        cyc();
        issue(1, 1, 13, 1'b0);
        #1 chk("busy_exec", 32'(alu_in_usage[1]), 32'd1);
        chk("err_not_yet", 32'(issue_err), 32'd0);
        cyc();
        #1 chk("err_set", 32'(issue_err), 32'd1);
        cyc();
        cyc();
        #1 chk("err_sticky", 32'(issue_err), 32'd1);

        // squash with lane0 in EXEC and lane1 stalled in WB
        cdb_ready = 2'b01;
        issue(0, 5, 21, 1'b1);
        issue(1, 2, 20, 1'b1);
        cyc();
        cyc();
        squash = 1'b1;
        issue(0, 1, 22, 1'b0);
        #1 chk("squash_cyc_valid", 32'(cdb_valid), 32'b10);
        chk("squash_cyc_usage", 32'(alu_in_usage), 32'b11);
        chk("squash_cyc_tag1", 32'(cdb_prf_idx[1]), 32'd20);
        cyc();
        squash = 1'b0;
        flush();
        cdb_ready = 2'b11;
        #1 chk("post_squash_valid", 32'(cdb_valid), 32'd0);
        chk("post_squash_usage", 32'(alu_in_usage), 32'd0);
        chk("post_squash_prf", 32'(cdb_prf_idx), 32'd0);
        cyc();
        #1 chk("dropped_issue", 32'(cdb_valid), 32'd0);
        chk("err_kept_by_squash", 32'(issue_err), 32'd1);
        cyc();

        // reset clears err; lat=0 acts as 1; max latency 7
        reset = 1'b1;
        #1 chk("err_cleared", 32'(issue_err), 32'd0);
        reset = 1'b0;
        issue(0, 0, 7, 1'b1);
        issue(1, 7, 30, 1'b1);
        #1 chk("usage_lat_issue", 32'(alu_in_usage), 32'd0);
        cyc();
        for (int i = 1; i <= 7; i++) begin
            #1 chk($sformatf("lat7_usage_%0d", i), 32'(alu_in_usage[1]), 32'(i < 7));
            cyc();
        end

        // async reset with lane0 stalled in WB and lane1 in EXEC
        cdb_ready = 2'b10;
        issue(0, 1, 40, 1'b1);
        issue(1, 5, 41, 1'b1);
        cyc();
        cyc();
        #1 chk("pre_rst_usage", 32'(alu_in_usage), 32'b11);
        chk("pre_rst_valid", 32'(cdb_valid), 32'b01);
        #1 reset = 1'b1;
        #1 chk("async_rst_usage", 32'(alu_in_usage), 32'd0);
        chk("async_rst_valid", 32'(cdb_valid), 32'd0);
        chk("async_rst_prf", 32'(cdb_prf_idx), 32'd0);
        #1 reset = 1'b0;
        flush();
        @(posedge clock);
        #1;
        cdb_ready = 2'b11;
        #1 chk("after_rst_valid", 32'(cdb_valid), 32'd0);
        chk("after_rst_usage", 32'(alu_in_usage), 32'd0);

        chk("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
        $finish;
    end

endmodule
